// File: rtl/video_capture.sv
// Receiver for 6-bit RGB + separate-sync video: synchronises the pins, recovers line/frame
// timing, tracks stability to declare lock, and emits active-window pixels with coordinates.
module video_capture #(
  parameter int HCNT_W      = 10,
  parameter int VCNT_W      = 9,
  parameter int H_START     = 96,
  parameter int H_LEN       = 256,
  parameter int V_START     = 64,
  parameter int V_LEN       = 192,
  parameter int LOCK_FRAMES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        vred,
  input  logic [1:0]        vgrn,
  input  logic [1:0]        vblu,
  input  logic              vhsync,
  input  logic              vvsync,
  output logic [5:0]        pixel,
  output logic              pix_stb,
  output logic [HCNT_W-1:0] hpos,
  output logic [VCNT_W-1:0] vpos,
  output logic              line_start,
  output logic              frame_start,
  output logic              locked,
  output logic [HCNT_W-1:0] line_len,
  output logic [VCNT_W-1:0] frame_lines
);

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  localparam logic [HCNT_W:0] H_LO   = (HCNT_W+1)'(H_START);
  localparam logic [HCNT_W:0] H_HI   = (HCNT_W+1)'(H_START + H_LEN);
  localparam logic [VCNT_W:0] V_LO   = (VCNT_W+1)'(V_START);
  localparam logic [VCNT_W:0] V_HI   = (VCNT_W+1)'(V_START + V_LEN);
  localparam logic [3:0]      LOCK_N = 4'(LOCK_FRAMES);

  logic [5:0]        col_s1_q, col_s1_d, col_s2_q, col_s2_d, col_s3_q, col_s3_d;
  logic [1:0]        sync_s1_q, sync_s1_d, sync_s2_q, sync_s2_d, sync_prev_q, sync_prev_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d, line_len_q, line_len_d, hpos_q, hpos_d;
  logic [VCNT_W-1:0] vcnt_q, vcnt_d, frame_lines_q, frame_lines_d, vpos_q, vpos_d;
  logic              vpend_q, vpend_d, lmis_q, lmis_d;
  logic [3:0]        mcnt_q, mcnt_d;
  state_t            state_q, state_d;
  logic              line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic              pix_stb_q, pix_stb_d;
  logic [5:0]        pixel_q, pixel_d;

  logic              hfall, vfall, frame_evt, timeout, line_diff, frame_ok, h_in, v_in;
  logic [HCNT_W-1:0] line_len_new;
  logic [VCNT_W-1:0] frame_lines_new;
  logic [3:0]        mcnt_inc;

  // Sync bit 1 is hsync, bit 0 is vsync; edges are seen one register after the synchroniser.
  assign hfall           = sync_prev_q[1] & ~sync_s2_q[1];
  assign vfall           = sync_prev_q[0] & ~sync_s2_q[0];
  assign frame_evt       = hfall & (vpend_q | vfall);
  assign timeout         = &hcnt_q;
  assign line_len_new    = hcnt_q + HCNT_W'(1);
  assign frame_lines_new = vcnt_q + VCNT_W'(1);
  assign line_diff       = hfall & (line_len_new != line_len_q);
  assign frame_ok        = ~(lmis_q | line_diff) & (frame_lines_new == frame_lines_q);
  assign h_in            = ({1'b0, hcnt_q} >= H_LO) && ({1'b0, hcnt_q} < H_HI);
  assign v_in            = ({1'b0, vcnt_q} >= V_LO) && ({1'b0, vcnt_q} < V_HI);
  assign mcnt_inc        = mcnt_q + 4'd1;

  always_comb begin
    col_s1_d      = {vred, vgrn, vblu};
    col_s2_d      = col_s1_q;
    col_s3_d      = col_s2_q;
    sync_s1_d     = {vhsync, vvsync};
    sync_s2_d     = sync_s1_q;
    sync_prev_d   = sync_s2_q;
    hcnt_d        = hfall ? '0 : (timeout ? hcnt_q : hcnt_q + HCNT_W'(1));
    vcnt_d        = vcnt_q;
    if (frame_evt) begin
      vcnt_d = '0;
    end else if (hfall && !(&vcnt_q)) begin
      vcnt_d = vcnt_q + VCNT_W'(1);
    end
    line_len_d    = hfall ? line_len_new : line_len_q;
    frame_lines_d = frame_evt ? frame_lines_new : frame_lines_q;
    vpend_d       = frame_evt ? 1'b0 : (vpend_q | vfall);
    // The line closing a frame is judged with that frame, then the flag restarts.
    lmis_d        = frame_evt ? 1'b0 : (lmis_q | line_diff);
    line_start_d  = hfall;
    frame_start_d = frame_evt;
  end

  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    case (state_q)
      HUNT: begin
        if (frame_evt) begin
          state_d = CHECK;
          mcnt_d  = '0;
        end
      end
      CHECK: begin
        if (timeout) begin
          state_d = HUNT;
        end else if (frame_evt) begin
          if (frame_ok) begin
            mcnt_d = mcnt_inc;
            if (mcnt_inc == LOCK_N) begin
              state_d = LOCKED;
            end
          end else begin
            mcnt_d = '0;
          end
        end
      end
      LOCKED: begin
        if (timeout || (frame_evt && !frame_ok)) begin
          state_d = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    pix_stb_d = (state_q == LOCKED) && h_in && v_in;
    pixel_d   = pix_stb_d ? col_s3_q : pixel_q;
    hpos_d    = pix_stb_d ? hcnt_q - HCNT_W'(H_START) : hpos_q;
    vpos_d    = pix_stb_d ? vcnt_q - VCNT_W'(V_START) : vpos_q;
  end

  // Sync flops reset high so releasing reset never fakes a falling edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_s1_q      <= '0;
      col_s2_q      <= '0;
      col_s3_q      <= '0;
      sync_s1_q     <= 2'b11;
      sync_s2_q     <= 2'b11;
      sync_prev_q   <= 2'b11;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      vpend_q       <= 1'b0;
      lmis_q        <= 1'b0;
      mcnt_q        <= '0;
      state_q       <= HUNT;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      pix_stb_q     <= 1'b0;
      pixel_q       <= '0;
      hpos_q        <= '0;
      vpos_q        <= '0;
    end else begin
      col_s1_q      <= col_s1_d;
      col_s2_q      <= col_s2_d;
      col_s3_q      <= col_s3_d;
      sync_s1_q     <= sync_s1_d;
      sync_s2_q     <= sync_s2_d;
      sync_prev_q   <= sync_prev_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      vpend_q       <= vpend_d;
      lmis_q        <= lmis_d;
      mcnt_q        <= mcnt_d;
      state_q       <= state_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      pix_stb_q     <= pix_stb_d;
      pixel_q       <= pixel_d;
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
    end
  end

  assign pixel       = pixel_q;
  assign pix_stb     = pix_stb_q;
  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign locked      = (state_q == LOCKED);
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;

endmodule

// File: tb/tb_video_capture.sv
// Self-checking bench for video_capture: drives directed and randomised video frames and compares
// every output each cycle against a pin-timestamp reference model, plus lock-milestone checks.
module tb_video_capture;

  localparam int HW = 7, VW = 5;
  localparam int HS = 8, HL = 16, VS = 4, VL = 6, LF = 3;
  localparam int HMAX = (1 << HW) - 1, VMAX = (1 << VW) - 1;
  localparam int MAXC = 50000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    vred, vgrn, vblu;
  logic          vhsync, vvsync;
  logic [5:0]    pixel;
  logic          pix_stb, line_start, frame_start, locked;
  logic [HW-1:0] hpos, line_len;
  logic [VW-1:0] vpos, frame_lines;

  video_capture #(
    .HCNT_W(HW), .VCNT_W(VW), .H_START(HS), .H_LEN(HL),
    .V_START(VS), .V_LEN(VL), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vred(vred), .vgrn(vgrn), .vblu(vblu),
    .vhsync(vhsync), .vvsync(vvsync), .pixel(pixel), .pix_stb(pix_stb),
    .hpos(hpos), .vpos(vpos), .line_start(line_start), .frame_start(frame_start),
    .locked(locked), .line_len(line_len), .frame_lines(frame_lines)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  bit hs_h[MAXC], vs_h[MAXC], rst_h[MAXC];
  logic [5:0] col_h[MAXC];

  int h_anchor, lines_since, ll_m, fl_m, good_run, stb_count;
  bit vpend_m, lmis_m, tracking, locked_m, locked_whole, e_ls, e_fs, e_stb;
  int e_pix, e_hpos, e_vpos;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: observed %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int hc(input int m);
    int d;
    d = m - h_anchor;
    return (d > HMAX) ? HMAX : d;
  endfunction

  // Model of edge m: events at the counters lag the pins by two synchroniser stages.
  task automatic modelStep(input int m);
    int hprev, vprev, newll, newfl;
    bit hf, vf, fe, tmo, cons, mism;
    if (!rst_h[m]) begin
      for (int k = 0; k < 3; k++) begin
        if (m - k >= 0) begin
          hs_h[m-k] = 1'b1; vs_h[m-k] = 1'b1; col_h[m-k] = '0;
        end
      end
      h_anchor = m; lines_since = 0; ll_m = 0; fl_m = 0; good_run = 0;
      vpend_m = 0; lmis_m = 0; tracking = 0; locked_m = 0; locked_whole = 0;
      e_ls = 0; e_fs = 0; e_stb = 0; e_pix = 0; e_hpos = 0; e_vpos = 0; stb_count = 0;
      return;
    end
    hprev = hc(m - 1);
    vprev = (lines_since > VMAX) ? VMAX : lines_since;
    e_stb = locked_m && hprev >= HS && hprev < HS + HL && vprev >= VS && vprev < VS + VL;
    if (e_stb) begin
      e_pix = col_h[m-3]; e_hpos = hprev - HS; e_vpos = vprev - VS;
    end
    hf   = hs_h[m-3] && !hs_h[m-2];
    vf   = vs_h[m-3] && !vs_h[m-2];
    fe   = hf && (vpend_m || vf);
    tmo  = (hprev == HMAX);
    cons = 0;
    if (hf) begin
      newll = (hprev + 1) % (HMAX + 1);
      mism  = (newll != ll_m);
      if (fe) begin
        newfl = (vprev + 1) % (VMAX + 1);
        cons  = !(lmis_m || mism) && (newfl == fl_m);
        fl_m = newfl; lmis_m = 0; lines_since = 0; vpend_m = 0;
      end else begin
        lmis_m = lmis_m || mism;
        lines_since++;
      end
      ll_m = newll; h_anchor = m;
    end
    if (vf && !fe) vpend_m = 1;
    if (!tracking) begin
      if (fe) begin tracking = 1; good_run = 0; end
    end else if (!locked_m) begin
      if (tmo) tracking = 0;
      else if (fe) begin
        if (cons) begin
          good_run++;
          if (good_run == LF) locked_m = 1;
        end else good_run = 0;
      end
    end else if (tmo || (fe && !cons)) begin
      locked_m = 0; tracking = 0;
    end
    e_ls = hf; e_fs = fe;
    stb_count += int'(pix_stb);
    if (fe) begin
      if (locked_whole) checkOutput("stb_per_frame", stb_count, HL * VL);
      locked_whole = locked_m; stb_count = 0;
    end else if (!locked_m) locked_whole = 0;
  endtask

  task automatic stepCycle(input bit h, input bit v, input bit r, input logic [5:0] col);
    if (cyc + 2 >= MAXC) begin
      errors++;
      $display("[TB] FAIL cycle_budget: observed %0d cycles, limit %0d", cyc, MAXC);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
    vhsync = h; vvsync = v; rst_n = r; {vred, vgrn, vblu} = col;
    hs_h[cyc+1] = h; vs_h[cyc+1] = v; rst_h[cyc+1] = r; col_h[cyc+1] = col;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    modelStep(cyc);
    checkOutput("line_start", line_start, e_ls);
    checkOutput("frame_start", frame_start, e_fs);
    checkOutput("locked", locked, locked_m);
    checkOutput("line_len", line_len, ll_m);
    checkOutput("frame_lines", frame_lines, fl_m);
    checkOutput("pix_stb", pix_stb, e_stb);
    checkOutput("pixel", pixel, e_pix);
    checkOutput("hpos", hpos, e_hpos);
    checkOutput("vpos", vpos, e_vpos);
  endtask

  // One frame: vsync falls vOff clocks into line 0 and stays low for two lines.
  task automatic applyStimulus(input int lineLen, input int nLines, input int hsW, input int vOff,
                               input int oddLine, input int oddLen, input int rstLine,
                               input int rstCol, input bit ramp);
    int len;
    bit v, r;
    for (int ln = 0; ln < nLines; ln++) begin
      len = (ln == oddLine) ? oddLen : lineLen;
      for (int c = 0; c < len; c++) begin
        v = !((ln == 0 && c >= vOff) || ln == 1 || (ln == 2 && c < vOff));
        r = !(ln == rstLine && c == rstCol);
        stepCycle(c >= hsW, v, r, ramp ? 6'(c) : 6'($urandom));
        if (!r) begin
          checkOutput("rst_locked", locked, 0);
          checkOutput("rst_pix_stb", pix_stb, 0);
          checkOutput("rst_line_len", line_len, 0);
          checkOutput("rst_frame_lines", frame_lines, 0);
          checkOutput("rst_pixel", pixel, 0);
        end
      end
    end
  endtask

  initial begin
    int len, odd;
    rst_n = 0; vhsync = 1; vvsync = 1; {vred, vgrn, vblu} = '0;
    hs_h[0] = 1; vs_h[0] = 1; rst_h[0] = 0; col_h[0] = '0;
    @(negedge clk);
    repeat (5) stepCycle(1, 1, 0, '0);
    repeat (10) stepCycle(1, 1, 1, '0);

    repeat (6) applyStimulus(40, 14, 4, 0, -1, 0, -1, 0, 1);
    checkOutput("lock_stable", locked, 1);
    checkOutput("line_len_stable", line_len, 40);
    checkOutput("frame_lines_stable", frame_lines, 14);

    applyStimulus(40, 14, 4, 0, 7, 39, -1, 0, 0);
    checkOutput("lock_hold_short", locked, 1);
    applyStimulus(40, 14, 4, 0, -1, 0, -1, 0, 0);
    checkOutput("lock_drop_short", locked, 0);
    repeat (3) applyStimulus(40, 14, 4, 0, -1, 0, -1, 0, 0);
    checkOutput("lock_not_early", locked, 0);
    applyStimulus(40, 14, 4, 0, -1, 0, -1, 0, 0);
    checkOutput("lock_regained", locked, 1);

    applyStimulus(40, 14, 4, 0, 5, 150, -1, 0, 0);
    checkOutput("lock_drop_timeout", locked, 0);
    checkOutput("stb_after_timeout", pix_stb, 0);

    repeat (5) applyStimulus(40, 14, 4, 10, -1, 0, -1, 0, 1);
    checkOutput("lock_voff", locked, 1);
    checkOutput("frame_lines_voff", frame_lines, 14);

    applyStimulus(40, 14, 4, 10, -1, 0, 7, 12, 0);
    repeat (4) applyStimulus(40, 14, 4, 10, -1, 0, -1, 0, 0);
    checkOutput("rst_no_early_lock", locked, 0);
    applyStimulus(40, 14, 4, 10, -1, 0, -1, 0, 0);
    checkOutput("rst_relock", locked, 1);

    for (int f = 0; f < 12; f++) begin
      len = $urandom_range(36, 44);
      odd = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 12) : -1;
      applyStimulus(len, 14, $urandom_range(2, 6),
                    ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(3, 30),
                    odd, len + (($urandom_range(0, 1) == 0) ? -1 : 1), -1, 0,
                    1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
